// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic ops, bit-serial SLL/SRL (one bit per cycle).
// One operation in flight; result_o is held until the next completion.
module seq_alu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [3:0]            ALU_Operation_i,
    input  logic [DATA_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0] B_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  zero_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_LUI = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;

    state_t                state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] work_q, work_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  done_q, done_d;

    // Shifts by zero also go through here, so they finish in a single cycle.
    function automatic logic [DATA_WIDTH-1:0] alu_eval(
        input logic [3:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        case (op)
            OP_ADD:  alu_eval = a + b;
            OP_SUB:  alu_eval = a - b;
            OP_OR:   alu_eval = a | b;
            OP_SLL:  alu_eval = a << b[4:0];
            OP_SRL:  alu_eval = a >> b[4:0];
            OP_LUI:  alu_eval = b;
            OP_AND:  alu_eval = a & b;
            OP_XOR:  alu_eval = a ^ b;
            default: alu_eval = '0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    op_d   = ALU_Operation_i;
                    work_d = A_i;
                    cnt_d  = B_i[4:0];
                    if ((ALU_Operation_i == OP_SLL || ALU_Operation_i == OP_SRL)
                        && B_i[4:0] != 5'd0) begin
                        state_d = SHIFT;
                    end else begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = alu_eval(ALU_Operation_i, A_i, B_i);
                    end
                end
            end
            SHIFT: begin
                work_d = (op_q == OP_SLL) ? (work_q << 1) : (work_q >> 1);
                cnt_d  = cnt_q - 5'd1;
                // The last shift step lands directly in result_o as DONE is entered.
                if (cnt_q == 5'd1) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = work_d;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_o   = (state_q != IDLE);
    assign done_o   = done_q;
    assign result_o = result_q;
    assign zero_o   = (result_q == '0);

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed scenarios plus randomized ops against a
// behavioural model of results and latencies.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_i = 1'b0;
    logic [3:0]  op_i = 4'd0;
    logic [31:0] a_i = 32'd0;
    logic [31:0] b_i = 32'd0;
    logic        busy, done, zero;
    logic [31:0] result;

    int total = 0;
    int bad = 0;

    seq_alu #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .ALU_Operation_i(op_i),
        .A_i(a_i), .B_i(b_i), .busy_o(busy), .done_o(done),
        .result_o(result), .zero_o(zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint unsigned la = 64'(a);
        longint unsigned lb = 64'(b);
        longint unsigned p2 = 64'd1 << b[4:0];
        case (op)
            4'd0: return 32'(la + lb);
            4'd1: return 32'(la + 64'h1_0000_0000 - lb);
            4'd2: return a | b;
            4'd3: return 32'(la * p2);
            4'd4: return 32'(la / p2);
            4'd5: return b;
            4'd6: return a & b;
            4'd7: return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
        int n = int'(b[4:0]);
        if ((op == 4'd3 || op == 4'd4) && n != 0) return n + 1;
        return 1;
    endfunction

    // Issues one op and observes it until done_o (bounded), then one more cycle.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble, input bit spam,
                          output int lat, output logic [31:0] res, output logic z,
                          output bit busy_ok, output bit idle_after);
        lat = -1; res = 32'd0; z = 1'b0; busy_ok = 1'b1; idle_after = 1'b0;
        @(negedge clk);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(posedge clk); #1;
        start_i = spam;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = c; res = result; z = zero; start_i = 1'b0;
            end else begin
                if (scramble) begin
                    a_i = $urandom; b_i = $urandom; op_i = 4'($urandom);
                end
                @(posedge clk); #1;
            end
        end
        start_i = 1'b0;
        @(posedge clk); #1;
        idle_after = !busy && !done;
    endtask

    task automatic test_reset;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL rst_result: got %h want 0", result); end
        total++; if (zero !== 1'b1) begin bad++; $display("FAIL rst_zero: got %b want 1", zero); end
        start_i = 1'b1; op_i = 4'd0; a_i = 32'd1; b_i = 32'd2;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL rst_hold: got busy=%b done=%b want 0 0", busy, done);
        end
        start_i = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // First op after reset release; its start lands on the first rising edge.
    task automatic test_add;
        int lat; logic [31:0] res; logic z; bit bok, idl;
        run_op(4'd0, 32'd5, 32'd3, 1'b0, 1'b0, lat, res, z, bok, idl);
        total++; if (lat != 1) begin bad++; $display("FAIL add_lat: got %0d want 1", lat); end
        total++; if (res !== 32'd8) begin bad++; $display("FAIL add_res: got %h want 8", res); end
        total++; if (z !== 1'b0) begin bad++; $display("FAIL add_zero: got %b want 0", z); end
        total++; if (!bok) begin bad++; $display("FAIL add_busy: got busy low while in flight, want high"); end
        total++; if (!idl) begin bad++; $display("FAIL add_idle: got not idle after done, want idle"); end
    endtask

    task automatic test_sub;
        int lat; logic [31:0] res; logic z; bit bok, idl;
        run_op(4'd1, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, lat, res, z, bok, idl);
        total++; if (lat != 1) begin bad++; $display("FAIL sub0_lat: got %0d want 1", lat); end
        total++; if (res !== 32'd0) begin bad++; $display("FAIL sub0_res: got %h want 0", res); end
        total++; if (z !== 1'b1) begin bad++; $display("FAIL sub0_zero: got %b want 1", z); end
        run_op(4'd1, 32'd0, 32'd1, 1'b0, 1'b0, lat, res, z, bok, idl);
        total++; if (res !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sub_wrap: got %h want ffffffff", res); end
        total++; if (z !== 1'b0) begin bad++; $display("FAIL sub_wrap_zero: got %b want 0", z); end
    endtask

    task automatic test_sll31;
        int lat; logic [31:0] res; logic z; bit bok, idl;
        run_op(4'd3, 32'd1, 32'd31, 1'b1, 1'b0, lat, res, z, bok, idl);
        total++; if (lat != 32) begin bad++; $display("FAIL sll31_lat: got %0d want 32", lat); end
        total++; if (res !== 32'h8000_0000) begin bad++; $display("FAIL sll31_res: got %h want 80000000", res); end
        total++; if (!bok) begin bad++; $display("FAIL sll31_busy: got busy low during shift, want high"); end
        total++; if (!idl) begin bad++; $display("FAIL sll31_idle: got not idle after done, want idle"); end
    endtask

    task automatic test_srl;
        int lat; logic [31:0] res; logic z; bit bok, idl;
        run_op(4'd4, 32'h8000_0000, 32'd0, 1'b0, 1'b0, lat, res, z, bok, idl);
        total++; if (lat != 1) begin bad++; $display("FAIL srl0_lat: got %0d want 1", lat); end
        total++; if (res !== 32'h8000_0000) begin bad++; $display("FAIL srl0_res: got %h want 80000000", res); end
        run_op(4'd4, 32'h8000_0000, 32'd4, 1'b1, 1'b0, lat, res, z, bok, idl);
        total++; if (lat != 5) begin bad++; $display("FAIL srl4_lat: got %0d want 5", lat); end
        total++; if (res !== 32'h0800_0000) begin bad++; $display("FAIL srl4_res: got %h want 08000000", res); end
    endtask

    task automatic test_spam_start;
        int lat; logic [31:0] res; logic z; bit bok, idl;
        int extra_done = 0;
        logic [31:0] a = $urandom;
        run_op(4'd3, a, 32'd8, 1'b0, 1'b1, lat, res, z, bok, idl);
        total++; if (lat != 9) begin bad++; $display("FAIL spam_lat: got %0d want 9", lat); end
        total++; if (res !== ref_result(4'd3, a, 32'd8)) begin
            bad++; $display("FAIL spam_res: got %h want %h", res, ref_result(4'd3, a, 32'd8));
        end
        total++; if (!idl) begin bad++; $display("FAIL spam_idle: got not idle after done, want idle"); end
        repeat (5) begin
            @(posedge clk); #1;
            if (done || busy) extra_done++;
        end
        total++; if (extra_done != 0) begin bad++; $display("FAIL spam_queued: got %0d busy/done cycles want 0", extra_done); end
    endtask

    // Start held high: accepted every other cycle, so done_o toggles on odd cycles.
    task automatic test_back_to_back;
        int pattern_bad = 0;
        @(negedge clk);
        start_i = 1'b1; op_i = 4'd7; a_i = 32'hF0F0_F0F0; b_i = 32'h0FF0_0FF0;
        @(posedge clk); #1;
        for (int c = 1; c <= 10; c++) begin
            if (done !== (c % 2 == 1)) pattern_bad++;
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (pattern_bad != 0) begin bad++; $display("FAIL b2b_pattern: got %0d wrong cycles want 0", pattern_bad); end
        total++; if (result !== 32'hFF00_FF00) begin bad++; $display("FAIL b2b_res: got %h want ff00ff00", result); end
    endtask

    task automatic test_reset_mid;
        int lat; logic [31:0] res; logic z; bit bok, idl;
        int seen = 0;
        run_op(4'd0, 32'h10, 32'h20, 1'b0, 1'b0, lat, res, z, bok, idl);
        @(negedge clk);
        start_i = 1'b1; op_i = 4'd3; a_i = 32'd1; b_i = 32'd10;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL abort_ctrl: got busy=%b done=%b want 0 0", busy, done);
        end
        total++; if (result !== 32'd0 || zero !== 1'b1) begin
            bad++; $display("FAIL abort_res: got %h zero=%b want 0 1", result, zero);
        end
        repeat (12) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL abort_done: got %0d pulses want 0", seen); end
        @(negedge clk);
        reset = 1'b1;
        run_op(4'd5, $urandom, 32'hABCD_E000, 1'b0, 1'b0, lat, res, z, bok, idl);
        total++; if (lat != 1 || res !== 32'hABCD_E000) begin
            bad++; $display("FAIL lui: got lat=%0d res=%h want 1 abcde000", lat, res);
        end
        @(negedge clk);
        start_i = 1'b1; op_i = 4'd0; a_i = 32'd7; b_i = 32'd9;
        @(posedge clk); #1;
        start_i = 1'b0;
        total++; if (done !== 1'b1 || result !== 32'd16) begin
            bad++; $display("FAIL done_pre: got done=%b res=%h want 1 10", done, result);
        end
        #1;
        reset = 1'b0;
        #1;
        total++; if (done !== 1'b0 || result !== 32'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL done_abort: got done=%b res=%h busy=%b want 0 0 0", done, result, busy);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_random;
        int lat; logic [31:0] res; logic z; bit bok, idl;
        logic [3:0] op; logic [31:0] a, b, exp;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            if (i % 4 == 0) b = 32'($urandom_range(0, 3));
            if (i % 7 == 0) a = b;
            exp = ref_result(op, a, b);
            run_op(op, a, b, 1'b1, 1'b0, lat, res, z, bok, idl);
            total++; if (lat != ref_latency(op, b) || res !== exp || z !== (exp == 32'd0) || !bok || !idl) begin
                bad++;
                $display("FAIL rand op=%h a=%h b=%h: got lat=%0d res=%h z=%b busy_ok=%b idle=%b want lat=%0d res=%h z=%b",
                         op, a, b, lat, res, z, bok, idl, ref_latency(op, b), exp, exp == 32'd0);
            end
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_sll31;
        test_srl;
        test_spam_start;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand and result width. The shift amount is fixed at 5 bits, so only DATA_WIDTH = 32 is supported.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low; asserting it low immediately forces the reset state, with no clock edge needed.
REQ-004 start_i  input  1  request to execute one operation; sampled on the rising edge of clk.
REQ-005 ALU_Operation_i  input  4  operation code from ALU_Control: 0000 ADD, 0001 SUB, 0010 OR, 0011 SLL, 0100 SRL, 0101 LUI, 0110 AND, 0111 XOR.
REQ-006 A_i  input  32  operand A (rs1).
REQ-007 B_i  input  32  operand B (rs2 or immediate); B_i[4:0] is the shift amount.
REQ-008 busy_o  output  1  high whenever the FSM is not in IDLE.
REQ-009 done_o  output  1  registered one-cycle pulse marking that result_o is valid and new.
REQ-010 result_o  output  32  registered result; holds its value until the next completion.
REQ-011 zero_o  output  1  equals 1 exactly when result_o == 0; derived combinationally from the result_o register.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 IDLE: if start_i = 1, the block SHALL latch ALU_Operation_i, A_i and B_i[4:0] into internal registers on that edge; later input changes SHALL not affect the operation.
REQ-014 IDLE transition, non-shift op or shift amount 0: the result SHALL be computed from the latched values and the FSM SHALL go to DONE on the edge after acceptance.
REQ-015 IDLE transition, SLL or SRL with amount n > 0: the FSM SHALL go to SHIFT with working register = A and counter = n.
REQ-016 SHIFT: each cycle the working register SHALL shift by one bit (SLL left, SRL logical right, zero fill) and the counter SHALL decrement.
REQ-017 SHIFT exit: when the counter reaches 0, the FSM SHALL go to DONE and load result_o with the working register.
REQ-018 Latency: done_o SHALL be high in cycle 1 after acceptance for non-shift ops and shift by 0, and in cycle 1+n for a shift by n; maximum latency is 32 cycles (n = 31).
REQ-019 DONE: done_o SHALL be high for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-020 start_i asserted while busy_o = 1 (including in DONE) SHALL be ignored and SHALL not be queued.
REQ-021 result_o SHALL be written only on entry to DONE; zero_o SHALL track result_o.
REQ-022 Arithmetic is modulo 2^32, with carry and overflow discarded:
- ADD = A + B
- SUB = A - B
- OR = A | B
- AND = A & B
- XOR = A ^ B
- LUI = B (pass-through; the immediate is already positioned)
REQ-023 Codes 1000-1111 SHALL complete with 1-cycle latency and result 0.
REQ-024 Back-to-back: the earliest next acceptance is the IDLE cycle after DONE, giving a minimum spacing of 2 cycles between starts.

Reset
REQ-025 While reset = 0, the block SHALL hold:
- state = IDLE
- busy_o = 0, done_o = 0
- result_o = 0, zero_o = 1
- counter, working register and latched operands = 0
REQ-026 Reset asserted mid-SHIFT or in DONE SHALL abort the operation, with no done_o pulse and result_o = 0.
REQ-027 After reset deasserts, a start on the first rising edge SHALL be accepted normally.

Verification
REQ-028 Apply ADD with A=0x0000_0005, B=0x0000_0003 and a 1-cycle start -> next cycle done_o=1, result_o=0x0000_0008, zero_o=0, busy_o=1 during DONE.
REQ-029 Apply SUB with A=B=0x1234_5678 -> result_o=0, zero_o=1 after 1 cycle; also SUB with A=0, B=1 -> result_o=0xFFFF_FFFF.
REQ-030 Apply SLL with A=0x0000_0001, B[4:0]=31 -> busy_o high, done_o pulses at cycle 32, result_o=0x8000_0000; toggling A_i and B_i during SHIFT leaves the result unchanged.
REQ-031 Apply SRL with A=0x8000_0000 and amount 0 -> done_o at cycle 1 with result_o=0x8000_0000; then SRL by 4 -> result_o=0x0800_0000 at cycle 5 (zero fill, not sign fill).
REQ-032 Pulse start_i every cycle while busy_o=1 during SLL by 8 -> exactly one done_o pulse; the next start is accepted only in IDLE.
REQ-033 Drive reset low at cycle 3 of SLL by 10 -> outputs immediately return to reset values, with no done_o; LUI with B=0xABCD_E000 after release -> result_o=0xABCD_E000 in 1 cycle.
